// File: rtl/frame_pkg.sv
// rtl/frame_pkg.sv - shared types for the frame builder
package frame_pkg;

    localparam int FRAME_W = 24;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    typedef struct packed {
        logic [7:0] dsap;
        logic [7:0] ssap;
        logic [7:0] data;
    } frame_t;

endpackage

// File: rtl/frame_fifo.sv
// rtl/frame_fifo.sv - power-of-two frame FIFO with registered occupancy count
import frame_pkg::*;

module frame_fifo #(
    parameter int DEPTH = 4
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   push,
    input  logic   pop,
    input  frame_t wr_frame,
    output frame_t head,
    output logic   full,
    output logic   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    frame_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage is not reset: stale entries are unreachable once count is zero.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_frame;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/frame_builder.sv
// rtl/frame_builder.sv - assembles {dsap, ssap, data} frames and strobes them toward the switch ingress
import frame_pkg::*;

module frame_builder #(
    parameter logic [7:0] SSAP    = 8'h00,
    parameter int         DEPTH   = 4,
    parameter int         N_PORTS = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tx_valid,
    output logic               tx_ready,
    input  logic [7:0]         tx_dsap,
    input  logic [7:0]         tx_data,
    output logic [FRAME_W-1:0] out,
    output logic               en,
    input  logic               out_ready,
    output logic [7:0]         drop_cnt,
    output logic [7:0]         frame_cnt
);

    localparam logic [8:0] PORT_LIMIT = (N_PORTS > 255) ? 9'd256 : 9'(N_PORTS);

    state_t state;
    frame_t head;
    frame_t last_frame;
    frame_t wr_frame;
    logic   full;
    logic   empty;
    logic   accept;
    logic   dsap_ok;
    logic   write;
    logic   drop;
    logic   pop;

    assign tx_ready = !full;
    assign accept   = tx_valid && tx_ready;
    assign dsap_ok  = ({1'b0, tx_dsap} < PORT_LIMIT);
    assign write    = accept && dsap_ok;
    assign drop     = accept && !dsap_ok;
    assign wr_frame = '{dsap: tx_dsap, ssap: SSAP, data: tx_data};

    assign en  = (state == SEND);
    assign pop = en && out_ready;
    // Between strobes the last presented frame stays visible on out.
    assign out = en ? head : last_frame;

    frame_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (write),
        .pop     (pop),
        .wr_frame(wr_frame),
        .head    (head),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            last_frame <= '0;
            drop_cnt   <= '0;
            frame_cnt  <= '0;
        end else begin
            case (state)
                IDLE:    state <= empty ? IDLE : SEND;
                SEND:    state <= out_ready ? GAP : SEND;
                GAP:     state <= empty ? IDLE : SEND;
                default: state <= IDLE;
            endcase
            if (state == SEND) begin
                last_frame <= head;
            end
            if (pop) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
            if (drop && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_frame_builder.sv
// tb/tb_frame_builder.sv - directed self-checking bench for frame_builder
module tb_frame_builder;

    logic        clk = 1'b0;
    logic        reset;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  tx_dsap;
    logic [7:0]  tx_data;
    logic [23:0] out;
    logic        en;
    logic        out_ready;
    logic [7:0]  drop_cnt;
    logic [7:0]  frame_cnt;

    int          checks   = 0;
    int          failures = 0;
    logic [23:0] got [$];
    logic        pop_now;
    logic        acc;
    logic        any_en;
    logic [7:0]  nxt;
    logic [23:0] exp_frame;

    always #5 clk = ~clk;

    frame_builder #(
        .SSAP   (8'h05),
        .DEPTH  (4),
        .N_PORTS(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_dsap  (tx_dsap),
        .tx_data  (tx_data),
        .out      (out),
        .en       (en),
        .out_ready(out_ready),
        .drop_cnt (drop_cnt),
        .frame_cnt(frame_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // reset held for two edges with a valid payload offered
        reset = 1'b0; tx_valid = 1'b1; tx_dsap = 8'h01; tx_data = 8'h33; out_ready = 1'b0;
        tick(); tick();
        chk("reset_en", en, 0);
        chk("reset_out", out, 24'h0);
        chk("reset_drop_cnt", drop_cnt, 0);
        chk("reset_frame_cnt", frame_cnt, 0);
        reset = 1'b1; tx_valid = 1'b0;
        tick();
        chk("release_tx_ready", tx_ready, 1);
        chk("release_en", en, 0);
        any_en = 1'b0;
        for (int i = 0; i < 4; i++) begin tick(); any_en |= en; end
        chk("reset_no_frame", any_en, 0);

        // single frame, 2-cycle latency, one-cycle strobe
        out_ready = 1'b1; tx_valid = 1'b1; tx_dsap = 8'h02; tx_data = 8'hA5;
        tick(); tx_valid = 1'b0;
        chk("single_latency_en", en, 0);
        tick();
        chk("single_en", en, 1);
        chk("single_out", out, 24'h0205A5);
        tick();
        chk("single_gap_en", en, 0);
        chk("single_frame_cnt", frame_cnt, 1);
        chk("single_hold_out", out, 24'h0205A5);
        tick();
        chk("single_idle_en", en, 0);

        // backpressure until full, then drain in order
        out_ready = 1'b0; tx_dsap = 8'h01;
        for (int i = 0; i < 4; i++) begin
            tx_valid = 1'b1; tx_data = 8'(8'h10 + i);
            tick();
        end
        chk("bp_full_ready", tx_ready, 0);
        chk("bp_en", en, 1);
        chk("bp_out", out, 24'h010510);
        tx_data = 8'h14;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_hold_ready", tx_ready, 0);
            chk("bp_hold_en", en, 1);
            chk("bp_hold_out", out, 24'h010510);
        end
        out_ready = 1'b1; got.delete();
        for (int c = 0; c < 20; c++) begin
            pop_now = en && out_ready;
            if (pop_now) got.push_back(out);
            acc = tx_valid && tx_ready;
            tick();
            if (acc) tx_valid = 1'b0;
            if (pop_now) chk("bp_gap", en, 0);
        end
        tx_valid = 1'b0;
        chk("bp_frames", got.size(), 5);
        for (int i = 0; i < 5; i++) begin
            exp_frame = {8'h01, 8'h05, 8'(8'h10 + i)};
            if (i < got.size()) chk("bp_order", got[i], exp_frame);
        end
        chk("bp_frame_cnt", frame_cnt, 6);
        chk("bp_drained_en", en, 0);

        // out-of-range destinations are dropped and counted, saturating
        tx_valid = 1'b1; tx_dsap = 8'h07; tx_data = 8'h77;
        tick(); tx_valid = 1'b0;
        chk("drop_one", drop_cnt, 1);
        any_en = 1'b0;
        for (int i = 0; i < 4; i++) begin tick(); any_en |= en; end
        chk("drop_no_en", any_en, 0);
        tx_valid = 1'b1; tx_dsap = 8'h04;
        tick(); tx_valid = 1'b0;
        chk("drop_boundary", drop_cnt, 2);
        tx_valid = 1'b1; tx_dsap = 8'hFF;
        for (int i = 0; i < 300; i++) begin tick(); any_en |= en; end
        tx_valid = 1'b0;
        chk("drop_saturate", drop_cnt, 8'hFF);
        chk("drop_no_en_bulk", any_en, 0);
        chk("drop_frame_cnt", frame_cnt, 6);
        chk("drop_ready", tx_ready, 1);

        // push on every pop with three entries buffered
        out_ready = 1'b0; tx_dsap = 8'h03;
        for (int i = 0; i < 3; i++) begin
            tx_valid = 1'b1; tx_data = 8'(8'h20 + i);
            tick();
        end
        tx_valid = 1'b0;
        chk("sim_en", en, 1);
        chk("sim_out", out, 24'h030520);
        out_ready = 1'b1; got.delete(); nxt = 8'h23;
        for (int c = 0; c < 25; c++) begin
            pop_now = en && out_ready;
            if (pop_now) begin
                got.push_back(out);
                if (nxt <= 8'h26) begin
                    tx_valid = 1'b1; tx_data = nxt; nxt = nxt + 8'd1;
                end
            end else begin
                tx_valid = 1'b0;
            end
            chk("sim_tx_ready", tx_ready, 1);
            tick();
            tx_valid = 1'b0;
        end
        chk("sim_frames", got.size(), 7);
        for (int i = 0; i < 7; i++) begin
            exp_frame = {8'h03, 8'h05, 8'(8'h20 + i)};
            if (i < got.size()) chk("sim_order", got[i], exp_frame);
        end
        chk("sim_frame_cnt", frame_cnt, 13);

        // reset while a frame is being presented
        out_ready = 1'b0; tx_dsap = 8'h01;
        for (int i = 0; i < 2; i++) begin
            tx_valid = 1'b1; tx_data = 8'(8'h30 + i);
            tick();
        end
        tx_valid = 1'b0;
        tick();
        chk("rs_pre_en", en, 1);
        reset = 1'b0;
        tick();
        chk("rs_en", en, 0);
        chk("rs_out", out, 24'h0);
        chk("rs_frame_cnt", frame_cnt, 0);
        chk("rs_drop_cnt", drop_cnt, 0);
        chk("rs_tx_ready", tx_ready, 1);
        reset = 1'b1; out_ready = 1'b1; any_en = 1'b0;
        for (int i = 0; i < 6; i++) begin tick(); any_en |= en; end
        chk("rs_no_stale", any_en, 0);
        tx_valid = 1'b1; tx_dsap = 8'h00; tx_data = 8'h40;
        tick(); tx_valid = 1'b0;
        chk("rs_fresh_latency", en, 0);
        tick();
        chk("rs_fresh_en", en, 1);
        chk("rs_fresh_out", out, 24'h000540);
        tick();
        chk("rs_fresh_gap", en, 0);
        chk("rs_fresh_cnt", frame_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
